// File: rtl/wb_regfile.sv
// wb_regfile: write-back stage register plus 32x32 register file with bypassed read ports
// Ports:
//   clk, rstn                      clock (posedge), asynchronous active-low reset
//   i_WB_stall                     hold the stage register and drop this cycle's input
//   i_WB_regWe/WRA/WRD             result arriving from MEM
//   i_RF_ra1/ra2 -> o_RF_rd1/rd2   combinational read ports, r0 reads as zero
//   o_WB_regWe/WRA/WRD             WB-stage result exported as a forwarding source
//   o_WB_retired                   count of committed non-r0 writes, wraps
module wb_regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NREGS  = 2**ADDR_W,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_WB_stall,
  input  logic              i_WB_regWe,
  input  logic [ADDR_W-1:0] i_WB_WRA,
  input  logic [DATA_W-1:0] i_WB_WRD,
  input  logic [ADDR_W-1:0] i_RF_ra1,
  input  logic [ADDR_W-1:0] i_RF_ra2,
  output logic [DATA_W-1:0] o_RF_rd1,
  output logic [DATA_W-1:0] o_RF_rd2,
  output logic              o_WB_regWe,
  output logic [ADDR_W-1:0] o_WB_WRA,
  output logic [DATA_W-1:0] o_WB_WRD,
  output logic [CNT_W-1:0]  o_WB_retired
);
  logic              regwe_q, regwe_d, pending_q, pending_d;
  logic [ADDR_W-1:0] wra_q, wra_d;
  logic [DATA_W-1:0] wrd_q, wrd_d;
  logic [CNT_W-1:0]  retired_q, retired_d;
  logic [DATA_W-1:0] regs_q [NREGS];
  logic [DATA_W-1:0] regs_d [NREGS];
  logic              commit;
  // pending limits each captured entry to a single commit, even while stalled
  assign commit = pending_q & regwe_q & (wra_q != '0);
  always_comb begin
    regwe_d   = i_WB_stall ? regwe_q : i_WB_regWe;
    wra_d     = i_WB_stall ? wra_q : i_WB_WRA;
    wrd_d     = i_WB_stall ? wrd_q : i_WB_WRD;
    pending_d = !i_WB_stall;
    retired_d = commit ? retired_q + CNT_W'(1) : retired_q;
    regs_d    = regs_q;
    if (commit) regs_d[wra_q] = wrd_q;
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      regwe_q   <= 1'b0;
      wra_q     <= '0;
      wrd_q     <= '0;
      pending_q <= 1'b0;
      retired_q <= '0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      regwe_q   <= regwe_d;
      wra_q     <= wra_d;
      wrd_q     <= wrd_d;
      pending_q <= pending_d;
      retired_q <= retired_d;
      regs_q    <= regs_d;
    end
  end
  // the uncommitted WB entry overrides the array so readers see it one cycle early
  assign o_RF_rd1     = (i_RF_ra1 == '0) ? '0 : (commit && wra_q == i_RF_ra1) ? wrd_q : regs_q[i_RF_ra1];
  assign o_RF_rd2     = (i_RF_ra2 == '0) ? '0 : (commit && wra_q == i_RF_ra2) ? wrd_q : regs_q[i_RF_ra2];
  assign o_WB_regWe   = commit;
  assign o_WB_WRA     = wra_q;
  assign o_WB_WRD     = wrd_q;
  assign o_WB_retired = retired_q;
endmodule

// File: tb/tb_wb_regfile.sv
// tb_wb_regfile: scoreboard bench for wb_regfile covering bypass, r0, back-to-back, stall and reset
module tb_wb_regfile;
  logic        clk = 1'b0, rstn = 1'b0, stall = 1'b0, we = 1'b0;
  logic [4:0]  wra = '0, ra1 = '0, ra2 = '0;
  logic [31:0] wrd = '0;
  logic [31:0] rd1, rd2, owrd, ret;
  logic [4:0]  owra;
  logic        owe;
  int          errors = 0, checks = 0;
  typedef struct {string tag; logic [31:0] v;} exp_t;
  exp_t sb[$];
  wb_regfile dut (
    .clk(clk), .rstn(rstn), .i_WB_stall(stall), .i_WB_regWe(we), .i_WB_WRA(wra), .i_WB_WRD(wrd),
    .i_RF_ra1(ra1), .i_RF_ra2(ra2), .o_RF_rd1(rd1), .o_RF_rd2(rd2),
    .o_WB_regWe(owe), .o_WB_WRA(owra), .o_WB_WRD(owrd), .o_WB_retired(ret)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.v = v;
    sb.push_back(e);
  endtask
  task automatic pop_cmp(input logic [31:0] got);
    exp_t e;
    if (sb.size() == 0) check("sb_empty", 32'd1, 32'd0);
    else begin
      e = sb.pop_front();
      check(e.tag, got, e.v);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #2;
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #2;
    push("rst_rd1", 32'h0); push("rst_ret", 32'h0); push("rst_we", 32'h0);
    #1; pop_cmp(rd1); pop_cmp(ret); pop_cmp(32'(owe));
    rstn = 1'b1;
    tick;
    for (int i = 0; i < 32; i++) begin
      ra1 = 5'(i);
      ra2 = 5'(31 - i);
      push("t1_rd1", 32'h0); push("t1_rd2", 32'h0);
      #1; pop_cmp(rd1); pop_cmp(rd2);
    end
    push("t1_ret", 32'h0); pop_cmp(ret);
    we = 1'b1; wra = 5'd5; wrd = 32'hDEADBEEF; ra1 = 5'd5;
    push("t2_bypass", 32'hDEADBEEF); push("t2_fwd_we", 32'h1); push("t2_fwd_wra", 32'h5); push("t2_ret0", 32'h0);
    tick; we = 1'b0; #1;
    pop_cmp(rd1); pop_cmp(32'(owe)); pop_cmp(32'(owra)); pop_cmp(ret);
    push("t2_array", 32'hDEADBEEF); push("t2_ret1", 32'h1); push("t2_fwd_off", 32'h0);
    tick; #1;
    pop_cmp(rd1); pop_cmp(ret); pop_cmp(32'(owe));
    we = 1'b1; wra = 5'd0; wrd = 32'h1234; ra1 = 5'd0;
    push("t3_rd0", 32'h0); push("t3_fwd_we", 32'h0); push("t3_fwd_wrd", 32'h1234);
    tick; we = 1'b0; #1;
    pop_cmp(rd1); pop_cmp(32'(owe)); pop_cmp(owrd);
    push("t3_ret", 32'h1);
    tick; #1; pop_cmp(ret);
    we = 1'b1; wra = 5'd7; wrd = 32'h1; ra1 = 5'd7; ra2 = 5'd7;
    push("t4_first", 32'h1);
    tick; wrd = 32'h2; #1; pop_cmp(rd1);
    push("t4_second", 32'h2); push("t4_second_p2", 32'h2);
    tick; we = 1'b0; #1; pop_cmp(rd1); pop_cmp(rd2);
    push("t4_final", 32'h2); push("t4_ret", 32'h3);
    tick; #1; pop_cmp(rd1); pop_cmp(ret);
    we = 1'b1; wra = 5'd3; wrd = 32'hA5; ra1 = 5'd3;
    push("t5_bypass", 32'hA5);
    tick; stall = 1'b1; wrd = 32'hFF; #1; pop_cmp(rd1);
    push("t5_commit", 32'hA5); push("t5_ret1", 32'h4); push("t5_fwd_off", 32'h0);
    tick; #1; pop_cmp(rd1); pop_cmp(ret); pop_cmp(32'(owe));
    push("t5_hold", 32'hA5); push("t5_ret_hold", 32'h4);
    tick; tick; #1; pop_cmp(rd1); pop_cmp(ret);
    stall = 1'b0;
    push("t5_next", 32'hFF);
    tick; we = 1'b0; #1; pop_cmp(rd1);
    push("t5_next_ret", 32'h5);
    tick; #1; pop_cmp(ret);
    we = 1'b1; wra = 5'd9; wrd = 32'h55; ra1 = 5'd9; ra2 = 5'd3;
    push("t6_bypass", 32'h55);
    tick; we = 1'b0; #1; pop_cmp(rd1);
    rstn = 1'b0;
    push("t6_rd9", 32'h0); push("t6_rd3", 32'h0); push("t6_ret", 32'h0); push("t6_wrd", 32'h0);
    #1; pop_cmp(rd1); pop_cmp(rd2); pop_cmp(ret); pop_cmp(owrd);
    rstn = 1'b1;
    push("t6_post_rd9", 32'h0); push("t6_post_ret", 32'h0); push("t6_post_we", 32'h0);
    tick; #1; pop_cmp(rd1); pop_cmp(ret); pop_cmp(32'(owe));
    if (sb.size() != 0) check("sb_leftover", 32'(sb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
